// File: rtl/bnn_pkg.sv
// Shared types and arithmetic helpers for the BNN systolic array processing elements.
package bnn_pkg;

  localparam int unsigned MAX_W = 128;

  typedef enum logic {
    MODE_FIX = 1'b0,
    MODE_BIN = 1'b1
  } mode_t;

  // Callers sign-extend into MAX_W and cast the result back down to w bits.
  function automatic logic signed [MAX_W-1:0] sat_acc(input logic signed [MAX_W-1:0] v,
                                                      input int unsigned w);
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
    hi = $signed((MAX_W'(1) << (w - 1)) - MAX_W'(1));
    lo = -hi - 1;
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

  function automatic int popcount(input logic [MAX_W-1:0] v);
    int n;
    n = 0;
    for (int unsigned i = 0; i < MAX_W; i++) n += int'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/pe_delay_line.sv
// Stall-aware valid/data shift register; data only advances behind a valid, so the tail holds the last valid word.
module pe_delay_line #(
  parameter int unsigned STAGES = 2,
  parameter int unsigned W      = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  generate
    if (STAGES == 0) begin : g_bypass
      assign o_valid = i_valid;
      assign o_data  = i_data;
    end else begin : g_shift
      logic [STAGES-1:0]        r_valid;
      logic [STAGES-1:0][W-1:0] r_data;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_valid <= '0;
          r_data  <= '0;
        end else if (i_en) begin
          r_valid[0] <= i_valid;
          if (i_valid) r_data[0] <= i_data;
          for (int unsigned i = 1; i < STAGES; i++) begin
            r_valid[i] <= r_valid[i-1];
            if (r_valid[i-1]) r_data[i] <= r_data[i-1];
          end
        end
      end

      assign o_valid = r_valid[STAGES-1];
      assign o_data  = r_data[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/array_element_pipe.sv
// Weight-stationary PE: fixed-point MAC or XNOR-popcount accumulate, saturating psum, LAT-cycle result pipeline.
module array_element_pipe
  import bnn_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned LAT    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              weight_load,
  input  logic [DATA_W-1:0] weight_in,
  input  logic              mode_in,
  output logic [DATA_W-1:0] weight_out,
  output logic              mode_out,
  input  logic              act_in_valid,
  input  logic [DATA_W-1:0] act_in,
  input  logic              psum_in_valid,
  input  logic [ACC_W-1:0]  psum_in,
  output logic              act_out_valid,
  output logic [DATA_W-1:0] act_out,
  output logic              psum_out_valid,
  output logic [ACC_W-1:0]  psum_out
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned SUM_W  = ACC_W + PROD_W;

  logic [DATA_W-1:0]       r_weight;
  mode_t                   r_mode;
  logic [DATA_W-1:0]       r_act;
  logic                    r_act_valid;
  logic                    r_s1_valid;
  logic signed [ACC_W-1:0] r_s1_psum;

  logic [DATA_W-1:0]        w_xnor;
  int                       w_pc;
  logic signed [PROD_W-1:0] w_fix_term;
  logic signed [PROD_W-1:0] w_bin_term;
  logic signed [PROD_W-1:0] w_term;
  logic signed [ACC_W-1:0]  w_psum_op;
  logic signed [SUM_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  w_sat;

  always_comb begin
    w_xnor     = ~(act_in ^ r_weight);
    w_pc       = popcount(MAX_W'(w_xnor));
    w_fix_term = PROD_W'($signed(act_in)) * PROD_W'($signed(r_weight));
    w_bin_term = PROD_W'(2 * w_pc - int'(DATA_W));
    w_term     = (r_mode == MODE_BIN) ? w_bin_term : w_fix_term;
    w_psum_op  = psum_in_valid ? $signed(psum_in) : '0;
    w_sum      = SUM_W'(w_term) + SUM_W'(w_psum_op);
    w_sat      = ACC_W'(sat_acc(MAX_W'(w_sum), ACC_W));
  end

  // Stage 1 sees the weight held before any same-cycle load, so in-flight entries keep the old weight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_weight    <= '0;
      r_mode      <= MODE_FIX;
      r_act       <= '0;
      r_act_valid <= 1'b0;
      r_s1_valid  <= 1'b0;
      r_s1_psum   <= '0;
    end else if (!stall) begin
      if (weight_load) begin
        r_weight <= weight_in;
        r_mode   <= mode_t'(mode_in);
      end
      r_act       <= act_in;
      r_act_valid <= act_in_valid;
      r_s1_valid  <= act_in_valid;
      if (act_in_valid) r_s1_psum <= w_sat;
    end
  end

  pe_delay_line #(
    .STAGES (LAT - 1),
    .W      (ACC_W)
  ) u_psum_dly (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (~stall),
    .i_valid (r_s1_valid),
    .i_data  (r_s1_psum),
    .o_valid (psum_out_valid),
    .o_data  (psum_out)
  );

  assign weight_out    = r_weight;
  assign mode_out      = r_mode;
  assign act_out       = r_act;
  assign act_out_valid = r_act_valid;

  a_psum_without_act : assert property (@(posedge clk) disable iff (!rst_n)
    !(psum_in_valid && !act_in_valid && !stall));

endmodule

// File: tb/tb_array_element_pipe.sv
// Scoreboard bench for array_element_pipe: directed and random stimulus against a behavioural PE model.
module tb_array_element_pipe;

  localparam int DATA_W = 16;
  localparam int ACC_W  = 24;
  localparam int LAT    = 3;

  logic              clk;
  logic              rst_n;
  logic              stall;
  logic              weight_load;
  logic [DATA_W-1:0] weight_in;
  logic              mode_in;
  logic [DATA_W-1:0] weight_out;
  logic              mode_out;
  logic              act_in_valid;
  logic [DATA_W-1:0] act_in;
  logic              psum_in_valid;
  logic [ACC_W-1:0]  psum_in;
  logic              act_out_valid;
  logic [DATA_W-1:0] act_out;
  logic              psum_out_valid;
  logic [ACC_W-1:0]  psum_out;

  array_element_pipe #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .LAT    (LAT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .weight_load    (weight_load),
    .weight_in      (weight_in),
    .mode_in        (mode_in),
    .weight_out     (weight_out),
    .mode_out       (mode_out),
    .act_in_valid   (act_in_valid),
    .act_in         (act_in),
    .psum_in_valid  (psum_in_valid),
    .psum_in        (psum_in),
    .act_out_valid  (act_out_valid),
    .act_out        (act_out),
    .psum_out_valid (psum_out_valid),
    .psum_out       (psum_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    longint val;
    int     k;
  } exp_t;

  exp_t              q[$];
  int                checks = 0;
  int                errors = 0;
  int                cyc    = 0;
  logic [DATA_W-1:0] mdl_w;
  logic              mdl_m;

  function automatic longint ref_psum(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] w,
                                      input logic m, input logic pv, input logic [ACC_W-1:0] ps);
    longint t, s, hi, lo;
    int ones;
    if (!m) begin
      t = longint'($signed(a)) * longint'($signed(w));
    end else begin
      ones = 0;
      for (int i = 0; i < DATA_W; i++) if (a[i] == w[i]) ones++;
      t = 2 * ones - DATA_W;
    end
    s  = t + (pv ? longint'($signed(ps)) : 64'sd0);
    hi = (64'sd1 <<< (ACC_W - 1)) - 1;
    lo = -hi - 1;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks held weight/mode and pushes expected results at each accepted entry.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_w <= '0;
      mdl_m <= 1'b0;
    end else if (!stall) begin
      if (act_in_valid)
        q.push_back(exp_t'{ref_psum(act_in, mdl_w, mdl_m, psum_in_valid, psum_in), cyc});
      if (weight_load) begin
        mdl_w <= weight_in;
        mdl_m <= mode_in;
      end
    end
  end

  always begin : monitor
    logic                    adv, av;
    logic [DATA_W-1:0]       a;
    logic signed [ACC_W-1:0] last;
    exp_t                    e;
    @(posedge clk);
    adv = rst_n && !stall;
    av  = act_in_valid;
    a   = act_in;
    if (!rst_n) last = '0;
    #1;
    if (adv) begin
      cyc++;
      chk("act_out_valid", act_out_valid, av);
      if (av) chk("act_out", act_out, a);
      chk("weight_out", weight_out, mdl_w);
      chk("mode_out", mode_out, mdl_m);
      if (psum_out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_psum_valid", 1, 0);
        end else begin
          e = q.pop_front();
          chk("psum_out", $signed(psum_out), e.val);
          chk("psum_latency", cyc, e.k + LAT);
        end
        last = $signed(psum_out);
      end else begin
        chk("psum_hold", $signed(psum_out), last);
      end
    end
  end

  task automatic drive(input logic ld, input logic [DATA_W-1:0] w, input logic m,
                       input logic av, input logic [DATA_W-1:0] a,
                       input logic pv, input logic [ACC_W-1:0] ps, input logic st);
    weight_load   = ld;
    weight_in     = w;
    mode_in       = m;
    act_in_valid  = av;
    act_in        = a;
    psum_in_valid = pv;
    psum_in       = ps;
    stall         = st;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic load(input logic [DATA_W-1:0] w, input logic m);
    drive(1'b1, w, m, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic entry(input logic [DATA_W-1:0] a, input logic pv, input logic [ACC_W-1:0] ps);
    drive(1'b0, '0, 1'b0, 1'b1, a, pv, ps, 1'b0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_psum_out_valid", psum_out_valid, 0);
    chk("rst_psum_out", psum_out, 0);
    chk("rst_act_out_valid", act_out_valid, 0);
    chk("rst_act_out", act_out, 0);
    chk("rst_weight_out", weight_out, 0);
    chk("rst_mode_out", mode_out, 0);
  endtask

  initial begin : watchdog
    #2_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : stim
    logic              ld, st, av, pv, m;
    logic [DATA_W-1:0] w, a;
    logic [ACC_W-1:0]  ps;

    rst_n = 1'b0;
    weight_load = 1'b0; weight_in = '0; mode_in = 1'b0; stall = 1'b0;
    act_in_valid = 1'b0; act_in = '0; psum_in_valid = 1'b0; psum_in = '0;
    @(negedge clk);
    drive(1'b1, 16'h1234, 1'b1, 1'b1, 16'h0055, 1'b1, ACC_W'(9), 1'b0);
    check_reset_outputs();
    rst_n = 1'b1;

    load(16'd5, 1'b0);          chk("shift_w5", $signed(weight_out), 5);
    load(DATA_W'(-3), 1'b0);    chk("shift_wm3", $signed(weight_out), -3);
    load(16'd7, 1'b0);          chk("shift_w7", $signed(weight_out), 7);

    load(16'd3, 1'b0);
    entry(DATA_W'(-4), 1'b1, ACC_W'(10));
    idle(LAT + 1);

    load(16'd100, 1'b0);
    entry(16'd100, 1'b1, ACC_W'(8388600));
    entry(DATA_W'(-100), 1'b1, ACC_W'(-8388600));
    idle(LAT + 1);

    load(16'hFFFF, 1'b1);
    entry(16'h00FF, 1'b0, '0);
    entry(16'hFFFF, 1'b0, '0);
    entry(16'h0000, 1'b0, '0);
    idle(LAT + 1);

    load(16'd2, 1'b0);
    drive(1'b1, 16'd5, 1'b0, 1'b1, 16'd1, 1'b1, '0, 1'b0);
    entry(16'd1, 1'b1, '0);
    idle(LAT + 1);

    for (int i = 0; i < 12; i++) begin
      av = (i % 2 == 0);
      st = (i == 5 || i == 6);
      drive(1'b0, '0, 1'b0, av, DATA_W'(i + 1), av, ACC_W'(i * 7), st);
    end
    idle(LAT + 1);

    repeat (400) begin
      ld = ($urandom_range(0, 9) == 0);
      st = ($urandom_range(0, 6) == 0);
      av = ($urandom_range(0, 3) != 0);
      pv = av && ($urandom_range(0, 1) == 1);
      m  = ($urandom_range(0, 2) == 0);
      w  = ($urandom_range(0, 1) == 1) ? DATA_W'($urandom) : DATA_W'(int'($urandom_range(0, 255)) - 128);
      a  = ($urandom_range(0, 1) == 1) ? DATA_W'($urandom) : DATA_W'(int'($urandom_range(0, 255)) - 128);
      case ($urandom_range(0, 3))
        0:       ps = ACC_W'(8388607 - int'($urandom_range(0, 300)));
        1:       ps = ACC_W'(-8388608 + int'($urandom_range(0, 300)));
        default: ps = ACC_W'($urandom);
      endcase
      drive(ld, w, m, av, a, pv, ps, st);
    end
    idle(LAT + 2);

    load(16'd9, 1'b0);
    entry(16'd2, 1'b1, ACC_W'(1));
    entry(16'd3, 1'b1, ACC_W'(2));
    rst_n = 1'b0;
    q.delete();
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    idle(LAT + 3);
    entry(16'd4, 1'b1, ACC_W'(-6));
    entry(16'd4, 1'b0, '0);
    idle(LAT + 3);

    chk("scoreboard_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
